fetch_seq_ctrl: RTL and testbench

//  Sequencer for the 2-wide instruction fetch memory. Generates the fetch PC and

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pair_fifo.sv | 44 ++++
 rtl/fetch_seq_ctrl.sv | 81 ++++++++
 tb/tb_fetch_seq_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, defaults and helpers for the fetch sequencer
package fetch_pkg;
  localparam int PC_STEP_DEF = 8;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
  } fetch_pair_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} fetch_state_e;
  // unread memory holes show up as X in simulation and count as zero words
  function automatic logic is_zero(input logic [31:0] w);
    return (w === 32'd0) || ((^w) === 1'bx);
  endfunction
endpackage

// File: rtl/fetch_pair_fifo.sv
// fetch_pair_fifo: shift-register pair buffer whose head is always entry 0
module fetch_pair_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_pair_t                  din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_pair_t                  head,
  output logic                         empty,
  output logic                         full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  fetch_pair_t q [DEPTH];
  fetch_pair_t q_n [DEPTH];
  logic do_pop, do_push;
  logic [AW-1:0] wr;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign head = q[0];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr = AW'(count - CW'(do_pop));
  always_comb begin
    q_n = q;
    if (do_pop) for (int i = 0; i < DEPTH - 1; i++) q_n[i] = q[i + 1];
    if (do_push) q_n[wr] = din;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) count <= '0;
    else begin
      count <= count + CW'(do_push) - CW'(do_pop);
      q <= q_n;
    end
endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: 2-wide fetch sequencer with pair buffer, redirect flush and end-of-program drain
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          PC_STEP    = PC_STEP_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ZERO_LIMIT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_inst1,
  input  logic [31:0] mem_inst2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst1,
  output logic [31:0] out_inst2,
  output logic        done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int ZW = $clog2(ZERO_LIMIT + 1);
  fetch_state_e state, state_n;
  logic [31:0] pc, inflight_pc;
  logic inflight_v, redir, push, pop, issue, empty, full, hit;
  logic [CW-1:0] count;
  logic [ZW-1:0] zero_cnt, cnt1, cnt2;
  fetch_pair_t din, head;
  assign redir = redirect_valid && state != DONE;
  assign pop = out_valid && out_ready;
  assign push = inflight_v && !redir;
  // a pop this cycle frees a slot for the read issued now
  assign issue = state == RUN && !redir &&
    ({1'b0, count} + (CW+1)'(inflight_v) < (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
  assign din = '{pc: inflight_pc, inst1: mem_inst1, inst2: mem_inst2};
  assign mem_pc = pc;
  assign out_valid = !empty;
  assign out_pc = head.pc;
  assign out_inst1 = head.inst1;
  assign out_inst2 = head.inst2;
  fetch_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (din),
    .count (count),
    .head  (head),
    .empty (empty),
    .full  (full)
  );
  always_comb begin
    cnt1 = is_zero(mem_inst1) ? (zero_cnt == ZW'(ZERO_LIMIT) ? zero_cnt : zero_cnt + ZW'(1)) : '0;
    cnt2 = is_zero(mem_inst2) ? (cnt1 == ZW'(ZERO_LIMIT) ? cnt1 : cnt1 + ZW'(1)) : '0;
    hit = push && (cnt1 == ZW'(ZERO_LIMIT) || cnt2 == ZW'(ZERO_LIMIT));
    state_n = redir ? RUN :
              (state == RUN && hit) ? DRAIN :
              (state == DRAIN && empty && !inflight_v) ? DONE : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= RUN;
      pc <= RESET_PC;
      inflight_v <= 1'b0;
      inflight_pc <= '0;
      zero_cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pc <= redir ? (redirect_pc & ~32'd3) : issue ? pc + 32'(PC_STEP) : pc;
      inflight_v <= issue;
      inflight_pc <= issue ? pc : inflight_pc;
      zero_cnt <= redir ? '0 : push ? cnt2 : zero_cnt;
      done <= state_n == DONE;
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: per-cycle vector tables plus an in-order pair scoreboard
module tb_fetch_seq_ctrl;
  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] emp;
    logic        edone;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic out_valid, done;
  logic [31:0] mem_pc, mem_inst1, mem_inst2, out_pc, out_inst1, out_inst2;
  logic [31:0] redirect_pc = '0, rd_addr = '0, sb_e;
  logic [31:0] img [256];
  logic [31:0] exp_q [$];
  vec_t tbl [$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fetch_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_pc         (mem_pc),
    .mem_inst1      (mem_inst1),
    .mem_inst2      (mem_inst2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst1      (out_inst1),
    .out_inst2      (out_inst2),
    .done           (done)
  );
  always @(posedge clk) rd_addr <= mem_pc;
  assign mem_inst1 = img[rd_addr[9:2]];
  assign mem_inst2 = img[rd_addr[9:2] + 8'd1];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      chk("sb_pc", out_pc, sb_e);
      chk("sb_inst1", out_inst1, img[sb_e[9:2]]);
      chk("sb_inst2", out_inst2, img[sb_e[9:2] + 8'd1]);
    end
  function automatic void init_img(input bit zeros);
    for (int i = 0; i < 256; i++) img[i] = 32'hC000_0000 + 32'(i) * 4;
    if (zeros) begin
      for (int i = 4; i <= 12; i++) img[i] = '0;
      for (int i = 14; i <= 23; i++) img[i] = '0;
      img[129] = '0;
    end
  endfunction
  function automatic void add(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] emp,
                              input logic ed);
    tbl.push_back('{r, rdy, rd, rpc, ev, epc, emp, ed});
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n = tbl[i].rst_n;
      out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("%s[%0d].out_pc", tag, i), out_pc, tbl[i].epc);
      chk($sformatf("%s[%0d].mem_pc", tag, i), mem_pc, tbl[i].emp);
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(tbl[i].edone));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    chk($sformatf("%s.sb_left", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tbl.delete();
  endtask
  initial begin
    init_img(0);
    do_reset();
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    for (int k = 2; k <= 4; k++) add(1, 1, 0, 0, 1, 32'(k - 2) * 8, 32'(k) * 8, 0);
    for (int k = 5; k <= 10; k++) add(1, 0, 0, 0, 1, 24, 40, 0);
    add(1, 1, 0, 0, 1, 24, 40, 0);
    for (int k = 12; k <= 14; k++) add(1, 1, 0, 0, 1, 32'(k - 8) * 8, 32'(k - 6) * 8, 0);
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(k) * 8);
    run_table("stream_stall");
    do_reset();
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    add(1, 1, 0, 0, 1, 0, 16, 0);
    add(1, 1, 0, 0, 1, 8, 24, 0);
    add(1, 0, 1, 32'h43, 1, 16, 32, 0);
    add(1, 1, 0, 0, 0, 0, 32'h40, 0);
    add(1, 1, 0, 0, 0, 0, 32'h48, 0);
    add(1, 1, 0, 0, 1, 32'h40, 32'h50, 0);
    add(1, 1, 0, 0, 1, 32'h48, 32'h58, 0);
    exp_q = '{32'h0, 32'h8, 32'h40, 32'h48};
    run_table("redirect");
    init_img(1);
    do_reset();
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    for (int k = 2; k <= 13; k++) add(1, 1, 0, 0, 1, 32'(k - 2) * 8, 32'(k) * 8, 0);
    add(1, 1, 0, 0, 1, 32'h60, 32'h68, 0);
    add(1, 1, 0, 0, 0, 0, 32'h68, 0);
    add(1, 1, 0, 0, 0, 0, 32'h68, 1);
    add(1, 1, 1, 32'h200, 0, 0, 32'h68, 1);
    for (int k = 18; k <= 20; k++) add(1, 1, 0, 0, 0, 0, 32'h68, 1);
    for (int k = 0; k <= 12; k++) exp_q.push_back(32'(k) * 8);
    run_table("zero_drain");
    do_reset();
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    for (int k = 2; k <= 11; k++) add(1, 1, 0, 0, 1, 32'(k - 2) * 8, 32'(k) * 8, 0);
    add(1, 0, 1, 32'h200, 1, 32'h50, 32'h60, 0);
    add(1, 1, 0, 0, 0, 0, 32'h200, 0);
    add(1, 1, 0, 0, 0, 0, 32'h208, 0);
    for (int k = 15; k <= 20; k++)
      add(1, 1, 0, 0, 1, 32'h200 + 32'(k - 15) * 8, 32'h200 + 32'(k - 13) * 8, 0);
    for (int k = 0; k <= 9; k++) exp_q.push_back(32'(k) * 8);
    for (int k = 0; k <= 5; k++) exp_q.push_back(32'h200 + 32'(k) * 8);
    run_table("redirect_on_limit");
    init_img(0);
    do_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 8, 0);
    add(1, 0, 0, 0, 1, 0, 16, 0);
    add(0, 0, 0, 0, 1, 0, 16, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 8, 0);
    add(1, 1, 0, 0, 1, 0, 16, 0);
    add(1, 1, 0, 0, 1, 8, 24, 0);
    add(1, 1, 0, 0, 1, 16, 32, 0);
    exp_q = '{32'h0, 32'h8, 32'h10};
    run_table("mid_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
